// File: rtl/lru_access_sequencer.sv
// -----------------------------------------------------------------------------
// lru_access_sequencer
//
// Routes every cache lookup through the LRU eviction-policy block. A hit pulses
// an age update for the accessed way. A miss first claims the lowest-index
// expired way as victim, then ages that victim as most-recent. Only one age
// update is ever in flight, and each update is bounded by TIMEOUT_CYCLES.
//
// Ports
//   clk                  in   rising-edge clock
//   reset_n              in   asynchronous active-low reset
//   req_valid/req_ready  in/out request handshake from cache control (ready in IDLE only)
//   req_miss             in   1 = miss (victim needed), 0 = hit
//   req_way              in   hit way index, ignored on miss
//   resp_valid/ready     out/in response handshake; response held until accepted
//   resp_way             out  echoed hit way or selected victim
//   resp_error           out  miss found no expired way
//   resp_timeout         out  age update did not complete in time
//   accessed_way         out  one-hot way to the policy, zero outside UPDATE
//   update_age           out  age update strobe to the policy
//   all_age_update_done  in   policy finished updating every way
//   eviction_target      in   policy expired-way vector
//   eviction_ready       in   OR of eviction_target
//
// Every output is a register or a pure decode of the state register, so there
// is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module lru_access_sequencer #(
    parameter  int NUM_WAYS       = 512,
    parameter  int TIMEOUT_CYCLES = 16,
    localparam int WAY_W          = $clog2(NUM_WAYS),
    localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_miss,
    input  logic [WAY_W-1:0]    req_way,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [WAY_W-1:0]    resp_way,
    output logic                resp_error,
    output logic                resp_timeout,
    output logic [NUM_WAYS-1:0] accessed_way,
    output logic                update_age,
    input  logic                all_age_update_done,
    input  logic [NUM_WAYS-1:0] eviction_target,
    input  logic                eviction_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        UPDATE = 2'd2,
        RESP   = 2'd3
    } seqState_e;

    // Counter value of the last cycle an update may wait before timing out.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    seqState_e        stateReg, stateNext;
    logic [WAY_W-1:0] wayReg, wayNext;
    logic [CNT_W-1:0] cntReg, cntNext;
    logic             errReg, errNext;
    logic             toReg, toNext;
    logic [WAY_W-1:0] lowestWay;

    // Priority encoder: scanning from the top down lets the lowest set bit
    // overwrite any higher one, so lowest index wins when several are expired.
    always_comb begin
        lowestWay = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (eviction_target[i]) begin
                lowestWay = WAY_W'(i);
            end
        end
    end

    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        stateNext = stateReg;
        wayNext   = wayReg;
        cntNext   = cntReg;
        errNext   = errReg;
        toNext    = toReg;
        unique case (stateReg)
            IDLE: begin
                if (req_valid) begin
                    cntNext = '0;
                    errNext = 1'b0;
                    toNext  = 1'b0;
                    if (req_miss) begin
                        stateNext = SELECT;
                    end else begin
                        wayNext   = req_way;
                        stateNext = UPDATE;
                    end
                end
            end
            SELECT: begin
                if (eviction_ready) begin
                    wayNext   = lowestWay;
                    stateNext = UPDATE;
                end else begin
                    // No expired way: report the error and skip the age update.
                    errNext   = 1'b1;
                    wayNext   = '0;
                    stateNext = RESP;
                end
            end
            UPDATE: begin
                // Done is checked before the timeout so it wins a same-cycle tie.
                if (all_age_update_done) begin
                    stateNext = RESP;
                end else if (cntReg == CNT_LAST) begin
                    toNext    = 1'b1;
                    stateNext = RESP;
                end else begin
                    cntNext = cntReg + CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateReg <= IDLE;
            wayReg   <= '0;
            cntReg   <= '0;
            errReg   <= 1'b0;
            toReg    <= 1'b0;
        end else begin
            stateReg <= stateNext;
            wayReg   <= wayNext;
            cntReg   <= cntNext;
            errReg   <= errNext;
            toReg    <= toNext;
        end
    end

    // Output decode from registered state only.
    assign req_ready    = (stateReg == IDLE);
    assign resp_valid   = (stateReg == RESP);
    assign update_age   = (stateReg == UPDATE);
    assign accessed_way = (stateReg == UPDATE) ? (NUM_WAYS'(1) << wayReg) : '0;
    assign resp_way     = wayReg;
    assign resp_error   = errReg;
    assign resp_timeout = toReg;

endmodule

// File: tb/tb_lru_access_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lru_access_sequencer
//
// Self-checking bench. Each transaction's expected outcome (way, flags, number
// of age-update cycles, accept-to-response latency) is derived from the
// behavioural rules: victim = smallest expired index, update lasts until done
// or TIMEOUT_CYCLES cycles, response follows one cycle later.
// -----------------------------------------------------------------------------
module tb_lru_access_sequencer;

    localparam int N  = 512;
    localparam int T  = 16;
    localparam int WW = $clog2(N);
    localparam int NEVER = 1000;  // done-delay meaning "policy never reports done"

    logic          clk;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_miss;
    logic [WW-1:0] req_way;
    logic          resp_valid;
    logic          resp_ready;
    logic [WW-1:0] resp_way;
    logic          resp_error;
    logic          resp_timeout;
    logic [N-1:0]  accessed_way;
    logic          update_age;
    logic          all_age_update_done;
    logic [N-1:0]  eviction_target;
    logic          eviction_ready;

    int total;
    int bad;

    lru_access_sequencer #(
        .NUM_WAYS      (N),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_miss           (req_miss),
        .req_way            (req_way),
        .resp_valid         (resp_valid),
        .resp_ready         (resp_ready),
        .resp_way           (resp_way),
        .resp_error         (resp_error),
        .resp_timeout       (resp_timeout),
        .accessed_way       (accessed_way),
        .update_age         (update_age),
        .all_age_update_done(all_age_update_done),
        .eviction_target    (eviction_target),
        .eviction_ready     (eviction_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One complete transaction: accept, observe update cycles, check the
    // response, optionally hold off resp_ready for 'hold' cycles, handshake.
    // k = update cycle (0-based) in which the policy raises done.
    task automatic run_txn(input string name, input bit miss, input int way,
                           input logic [N-1:0] tgt, input int victim,
                           input int k, input int hold);
        bit           expErr, expTo, seen;
        int           expWay, expUpd, expLat, lat, upd;
        logic [N-1:0] expOneHot;

        expErr    = miss && (victim < 0);
        expWay    = miss ? (expErr ? 0 : victim) : way;
        expUpd    = expErr ? 0 : ((k < T) ? k + 1 : T);
        expTo     = !expErr && (k >= T);
        expLat    = (miss ? 1 : 0) + expUpd + 1;
        expOneHot = '0;
        expOneHot[expWay] = 1'b1;

        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s req_ready: got 0 required 1", name);
            return;
        end

        req_valid       = 1'b1;
        req_miss        = miss;
        req_way         = WW'(way);
        eviction_target = tgt;
        eviction_ready  = |tgt;
        @(posedge clk);
        #1;
        // Scramble request fields: they must have been captured on the edge.
        req_valid = 1'b0;
        req_miss  = 1'($urandom);
        req_way   = WW'($urandom);

        lat  = 0;
        upd  = 0;
        seen = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat  = c;
                seen = 1'b1;
                all_age_update_done = 1'b0;
                break;
            end
            total++;
            if (update_age) begin
                if (accessed_way !== expOneHot) begin
                    bad++;
                    $display("FAIL %s accessed_way: got %h required %h", name, accessed_way, expOneHot);
                end
                all_age_update_done = (upd == k);
                upd++;
            end else begin
                if (accessed_way !== '0) begin
                    bad++;
                    $display("FAIL %s accessed_way_idle: got %h required 0", name, accessed_way);
                end
                all_age_update_done = 1'b0;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s resp_valid: never asserted within 100 cycles", name);
            return;
        end

        total++;
        if (lat != expLat) begin
            bad++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, expLat);
        end
        total++;
        if (upd != expUpd) begin
            bad++;
            $display("FAIL %s update_cycles: got %0d required %0d", name, upd, expUpd);
        end
        total++;
        if (resp_way !== WW'(expWay)) begin
            bad++;
            $display("FAIL %s resp_way: got %0d required %0d", name, resp_way, expWay);
        end
        total++;
        if (resp_error !== expErr) begin
            bad++;
            $display("FAIL %s resp_error: got %0b required %0b", name, resp_error, expErr);
        end
        total++;
        if (resp_timeout !== expTo) begin
            bad++;
            $display("FAIL %s resp_timeout: got %0b required %0b", name, resp_timeout, expTo);
        end

        // Back-pressure: response must stay put and new requests be ignored.
        if (hold > 0) begin
            req_valid = 1'b1;
            req_miss  = 1'b0;
            req_way   = WW'($urandom);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            total++;
            if (resp_valid !== 1'b1 || resp_way !== WW'(expWay) || req_ready !== 1'b0 ||
                resp_error !== expErr || resp_timeout !== expTo || update_age !== 1'b0) begin
                bad++;
                $display("FAIL %s hold[%0d]: got valid=%0b way=%0d ready=%0b err=%0b to=%0b upd=%0b required 1/%0d/0/%0b/%0b/0",
                         name, h, resp_valid, resp_way, req_ready, resp_error, resp_timeout, update_age,
                         expWay, expErr, expTo);
            end
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s after_handshake: got valid=%0b ready=%0b required 0/1", name, resp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        total++;
        if (req_ready !== 1'b1 || update_age !== 1'b0 || accessed_way !== '0 || resp_valid !== 1'b0 ||
            resp_way !== '0 || resp_error !== 1'b0 || resp_timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got ready=%0b upd=%0b acc=%0b valid=%0b way=%0d err=%0b to=%0b required 1/0/0/0/0/0/0",
                     req_ready, update_age, |accessed_way, resp_valid, resp_way, resp_error, resp_timeout);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_hit();
        run_txn("hit5", 1'b0, 5, '0, -1, 0, 0);
    endtask

    task automatic test_miss_multi();
        logic [N-1:0] tgt;
        tgt = '0;
        tgt[300] = 1'b1;
        tgt[7]   = 1'b1;
        run_txn("miss_7_300", 1'b1, 0, tgt, 7, 0, 0);
    endtask

    task automatic test_miss_noevict();
        run_txn("miss_none", 1'b1, 42, '0, -1, 0, 0);
    endtask

    task automatic test_timeout();
        run_txn("timeout", 1'b0, 77, '0, -1, NEVER, 0);
        run_txn("after_timeout", 1'b0, 78, '0, -1, 2, 0);
        // Done on the final allowed cycle must beat the timeout.
        run_txn("done_at_last", 1'b0, 79, '0, -1, T - 1, 0);
    endtask

    task automatic test_back_to_back();
        run_txn("backpressure", 1'b0, 123, '0, -1, 1, 10);
        run_txn("after_backpressure", 1'b0, 511, '0, -1, 0, 0);
    endtask

    task automatic test_reset_mid_update();
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid ready_before: got %0b required 1", req_ready);
        end
        req_valid = 1'b1;
        req_miss  = 1'b0;
        req_way   = WW'(200);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        all_age_update_done = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (update_age !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid update_age_before: got %0b required 1", update_age);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (update_age !== 1'b0 || accessed_way !== '0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid outputs: got upd=%0b acc=%0b valid=%0b ready=%0b required 0/0/0/1",
                     update_age, |accessed_way, resp_valid, req_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        run_txn("after_reset", 1'b0, 9, '0, -1, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            bit           miss;
            int           way, nb, idx, victim, k, hold;
            logic [N-1:0] tgt;
            miss   = 1'($urandom_range(0, 1));
            way    = $urandom_range(0, N - 1);
            nb     = $urandom_range(0, 3);
            tgt    = '0;
            victim = -1;
            for (int j = 0; j < nb; j++) begin
                idx = $urandom_range(0, N - 1);
                tgt[idx] = 1'b1;
                if (victim < 0 || idx < victim) victim = idx;
            end
            k    = $urandom_range(0, T + 3);
            hold = $urandom_range(0, 3);
            run_txn($sformatf("rand%0d", n), miss, way, tgt, victim, k, hold);
        end
    endtask

    initial begin
        total               = 0;
        bad                 = 0;
        reset_n             = 1'b0;
        req_valid           = 1'b0;
        req_miss            = 1'b0;
        req_way             = '0;
        resp_ready          = 1'b0;
        all_age_update_done = 1'b0;
        eviction_target     = '0;
        eviction_ready      = 1'b0;

        test_reset();
        test_hit();
        test_miss_multi();
        test_miss_noevict();
        test_timeout();
        test_back_to_back();
        test_reset_mid_update();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
